mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store access unit between a request/response handshake and a registered-read data cache
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [3:0]  cache_write_en,
  output logic [29:0] cache_addr,
  output logic [31:0] cache_in_data,
  input  logic [31:0] cache_out_data
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  type_q, type_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [29:0] caddr_q, caddr_d;

  logic        type_ok, align_ok, range_ok, legal;
  logic [3:0]  lane_mask;
  logic [31:0] store_data;
  logic [31:0] shifted;
  logic [31:0] load_data;

  // Legality of the incoming request: type, natural alignment and 16 KiB window
  always_comb begin
    type_ok = 1'b0;
    if (req_we) begin
      type_ok = (req_type == 3'b000) || (req_type == 3'b001) || (req_type == 3'b010);
    end else begin
      type_ok = (req_type == 3'b000) || (req_type == 3'b001) || (req_type == 3'b010) ||
                (req_type == 3'b100) || (req_type == 3'b101);
    end
    case (req_type[1:0])
      2'b01:   align_ok = ~req_addr[0];
      2'b10:   align_ok = (req_addr[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
    range_ok = (req_addr[31:14] == 18'd0);
    legal    = type_ok && align_ok && range_ok;
  end

  // Next-state and capture logic; cache_addr tracks the last accepted address
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    type_d  = type_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    caddr_d = caddr_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          type_d  = req_type;
          off_d   = req_addr[1:0];
          wdata_d = req_wdata;
          err_d   = ~legal;
          caddr_d = req_addr[31:2];
          state_d = legal ? ACCESS : RESP;
        end
      end
      ACCESS: state_d = RESP;
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      type_q  <= 3'b000;
      off_q   <= 2'b00;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
      caddr_q <= 30'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      type_q  <= type_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      caddr_q <= caddr_d;
    end
  end

  // Store lane enables and byte-lane replicated write data
  always_comb begin
    case (type_q[1:0])
      2'b00: begin
        lane_mask  = 4'b0001 << off_q;
        store_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        lane_mask  = 4'b0011 << off_q;
        store_data = {2{wdata_q[15:0]}};
      end
      default: begin
        lane_mask  = 4'b1111;
        store_data = wdata_q;
      end
    endcase
  end

  // Load alignment and sign/zero extension of the cache read word
  always_comb begin
    shifted = cache_out_data >> {off_q, 3'b000};
    case (type_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b101:  load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  // Outputs; reset masks everything so a store in flight is cancelled in the same cycle
  always_comb begin
    req_ready      = rst || (state_q == IDLE);
    resp_valid     = !rst && (state_q == RESP);
    resp_err       = !rst && (state_q == RESP) && err_q;
    resp_rdata     = (!rst && (state_q == RESP) && !we_q && !err_q) ? load_data : 32'd0;
    cache_write_en = (!rst && (state_q == ACCESS) && we_q && !err_q) ? lane_mask : 4'b0000;
    cache_in_data  = (!rst && (state_q == ACCESS) && we_q && !err_q) ? store_data : 32'd0;
    cache_addr     = rst ? 30'd0 : caddr_q;
  end

endmodule
